montgomery_mult: RTL
====================

MONTGOMERY_MULT -- requirements
Module: montgomery_mult

Interface
REQ-001 SHALL have parameter N, default 512, operand width in bits (bench also runs N=8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port in_a  input  N  multiplicand A, A < M.
REQ-006 SHALL have port in_b  input  N  multiplier B, B < M.
REQ-007 SHALL have port in_m  input  N  modulus M, odd, M < 2^N.
REQ-008 SHALL have port result  output  N  A*B*2^-N mod M, registered.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port busy  output  1  high from accept until done inclusive.

Function
REQ-011 SHALL implement radix-2 bit-serial Montgomery multiplication, LSB of A first, N iterations.
REQ-012 SHALL use states IDLE, ADD_B, ADD_M, SUB, DONE.
REQ-013 SHALL, in IDLE with start=1, latch in_a/in_b/in_m into internal registers, clear accumulator C and bit counter i, and go to ADD_B.
REQ-014 SHALL, in IDLE with start=0, remain in IDLE with C, i and result unchanged.
REQ-015 SHALL, in ADD_B, update C <= C + (A[i] ? B : 0) and go to ADD_M.
REQ-016 SHALL, in ADD_M, update C <= (C + (C[0] ? M : 0)) >> 1, with the shift taken from the full-width sum.
REQ-017 SHALL, in ADD_M, increment i and return to ADD_B when i < N-1; when i = N-1, go to SUB.
REQ-018 SHALL hold C in an N+3 bit register; no intermediate sum may overflow, since C < 2M before ADD_B and C + B < 3M < 2^(N+2).
REQ-019 SHALL, in SUB, set result <= (C >= M) ? C - M : C, truncated to N bits, and go to DONE.
REQ-020 SHALL, in DONE, assert done for exactly one cycle and go to IDLE unconditionally.
REQ-021 SHALL have a fixed latency: done is high in the cycle after the (2N+2)th rising edge counted from the edge that sampled start=1 (N=512: 1026; N=8: 18).
REQ-022 SHALL set busy=1 in ADD_B, ADD_M, SUB and DONE, and busy=0 in IDLE.
REQ-023 SHALL ignore start while busy=1, with no restart and no operand relatch.
REQ-024 SHALL make in_a/in_b/in_m don't-care after the accepting edge; changing them mid-operation does not affect result.
REQ-025 SHALL accept start asserted in the cycle immediately after done, with no dead cycle required.
REQ-026 SHALL hold result stable from the DONE state until the next SUB state, including through the next operation's ADD_B/ADD_M cycles.
REQ-027 SHALL, when inputs violate REQ-005..007, give an unspecified result but unchanged latency, with done still pulsed and no lock-up.

Reset
REQ-028 SHALL, with resetn=0 at a rising edge, force state=IDLE, C=0, i=0, result=0, done=0, busy=0.
REQ-029 SHALL give reset priority over start and over any in-flight operation; reset mid-operation aborts it with no done pulse.
REQ-030 SHALL accept start on the first edge with resetn=1 after reset.

Verification
REQ-031 SHALL cover: N=8, M=13, A=5, B=7, start for 1 cycle -> done exactly 18 edges later, result=1, busy high 18 cycles.
REQ-032 SHALL cover: N=8, M=13, A=12, B=12 issued the cycle after the previous done -> result=3, latency 18.
REQ-033 SHALL cover: N=512, A=0, B=M-1, M=2^511+1 -> result=0 at edge 1026; also A=2^512 mod M, B=5 -> result=5.
REQ-034 SHALL cover: N=8, start pulsed again at cycles 3 and 10 of a busy operation -> ignored, single done, result per REQ-031.
REQ-035 SHALL cover: N=8, resetn low at cycle 9 of an operation -> next cycle state IDLE, result=0, done=0, busy=0; fresh A=5, B=7 -> result=1.
REQ-036 SHALL cover: N=8, operands toggled randomly after accept -> result unchanged from REQ-031; random A,B<M, odd M sweep vs reference model.

Source files
------------

// File: rtl/montgomery_mult_if.sv
// Request/result bundle for the Montgomery multiplier.
// The requester drives start and operands; the multiplier returns result/done/busy.
// No flow control beyond busy: start is only honoured while busy is low.
interface montgomery_mult_if #(
  parameter int N = 512
);
  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;
  logic         busy;

  modport master (
    output start, in_a, in_b, in_m,
    input  result, done, busy
  );

  modport slave (
    input  start, in_a, in_b, in_m,
    output result, done, busy
  );
endinterface

// File: rtl/montgomery_mult.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-N mod M.
// Latency: done pulses 2N+2 cycles after the edge that accepts start (fixed).
// Backpressure: none; start is ignored while busy, operands are latched on accept.
module montgomery_mult #(
  parameter int N = 512
) (
  input  logic              clk,
  input  logic              resetn,
  montgomery_mult_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ADD_B, ADD_M, SUB, DONE} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  a_r, b_r, m_r, res_r;
  logic [N+2:0]  c_r;
  logic [IW-1:0] i_r;
  logic          done_r, busy_r;

  // Accumulator candidates; N+3 bits keeps C+B+M (< 4M) from overflowing.
  logic [N+2:0]  sum_b, sum_m, c_red;

  // Candidate accumulator values for each datapath step
  always_comb begin
    sum_b = c_r;
    sum_m = c_r;
    c_red = c_r;
    if (a_r[i_r]) sum_b = c_r + {3'b000, b_r};
    if (c_r[0])   sum_m = c_r + {3'b000, m_r};
    if (c_r >= {3'b000, m_r}) c_red = c_r - {3'b000, m_r};
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = ADD_B;
      ADD_B:   state_nx = ADD_M;
      ADD_M:   state_nx = (i_r == IW'(N - 1)) ? SUB : ADD_B;
      SUB:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      m_r    <= '0;
      c_r    <= '0;
      i_r    <= '0;
      res_r  <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= (state_nx == DONE);
      busy_r <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r <= bus.in_a;
            b_r <= bus.in_b;
            m_r <= bus.in_m;
            c_r <= '0;
            i_r <= '0;
          end
        end
        ADD_B: c_r <= sum_b;
        ADD_M: begin
          // Shift the full-width sum so the carry out of bit N+1 is kept
          c_r <= sum_m >> 1;
          i_r <= i_r + 1'b1;
        end
        SUB: res_r <= c_red[N-1:0];
        default: ;
      endcase
    end
  end

  assign bus.result = res_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;
endmodule
